// File: rtl/if_pc_unit_pkg.sv
// Shared constants, FSM encoding and payload types for the fetch-stage PC unit.
package if_pc_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned EXCODE_W = 5;

  localparam logic [XLEN-1:0] PC_RESET  = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [XLEN-1:0] IM_LO     = 32'h0000_3000;
  localparam logic [XLEN-1:0] IM_HI     = 32'h0000_6FFC;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  localparam logic [EXCODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXCODE_W-1:0] EXC_NONE = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  typedef struct packed {
    logic                exc;
    logic [EXCODE_W-1:0] excode;
  } fetch_exc_t;

endpackage

// File: rtl/if_pc_unit_addr_check.sv
// Fetch-address legality check (alignment and IM window); built only when IF_ADDR_CHECK_EN is defined.
`ifdef IF_ADDR_CHECK_EN
module if_addr_check
  import if_pc_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  output fetch_exc_t      res
);

  logic bad_c;

  assign bad_c      = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  assign res.exc    = bad_c;
  assign res.excode = bad_c ? EXC_ADEL : EXC_NONE;

endmodule
`endif

// File: rtl/if_pc_unit.sv
// Fetch-stage PC register and redirect sequencer (exception, eret, delayed branch/jump).
// Optional fetch-address exception check enabled by macro IF_ADDR_CHECK_EN.
module if_pc_unit
  import if_pc_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_F,
  input  logic                npc_sel_D,
  input  logic [XLEN-1:0]     npc_D,
  input  logic                exc_req,
  input  logic                eret_req,
  input  logic [XLEN-1:0]     epc,
  output logic [XLEN-1:0]     PC_F,
  output logic [XLEN-1:0]     PC4_F,
  output logic                BD_F,
  output logic                redir_F,
  output logic                exc_F,
  output logic [EXCODE_W-1:0] excode_F
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_d;
  logic            bd_d;
  logic            redir_d;

  // State and fetch-tag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      PC_F    <= PC_RESET;
      BD_F    <= 1'b0;
      redir_F <= 1'b0;
    end else begin
      state_q <= state_d;
      PC_F    <= pc_d;
      BD_F    <= bd_d;
      redir_F <= redir_d;
    end
  end

  // Next PC / tags: exc > eret > stall > D-stage target > sequential
  always_comb begin
    state_d = state_q;
    pc_d    = PC_F;
    bd_d    = BD_F;
    redir_d = redir_F;
    if (exc_req || eret_req) begin
      pc_d    = exc_req ? EXC_ENTRY : epc;
      bd_d    = 1'b0;
      redir_d = 1'b1;
      state_d = ST_REDIR;
    end else if (stall_F) begin
      state_d = ST_HOLD;
    end else begin
      pc_d    = npc_sel_D ? npc_D : PC_F + PC_STEP;
      bd_d    = npc_sel_D;
      redir_d = 1'b0;
      // A held redirect resumes its REDIR mode for one cycle before RUN
      case (state_q)
        ST_HOLD: state_d = redir_F ? ST_REDIR : ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign PC4_F = PC_F + PC_STEP;

`ifdef IF_ADDR_CHECK_EN
  fetch_exc_t fetch_exc;

  if_addr_check u_addr_check (
    .pc  (PC_F),
    .res (fetch_exc)
  );

  assign exc_F    = fetch_exc.exc;
  assign excode_F = fetch_exc.excode;
`else
  assign exc_F    = 1'b0;
  assign excode_F = EXC_NONE;
`endif

endmodule
